// File: rtl/echo_ctrl_sequencer.sv
// echo_ctrl_sequencer
// Sequences keypad parameter changes into the echo block. A delay change is
// made click-free: the gain ramps down to 0, the new tap is applied together
// with a buffer flush pulse, the gain is held at 0, then it ramps back up.
// All ramp and hold pacing uses the codec sample tick. Attenuation and
// bypass changes take effect on the next sample tick.
//
// Build option: define ECHO_CTRL_RAMP_EN to enable the ramp/hold sequence.
// Without it, pending delay steps are applied on the next sample tick and
// gain is fixed at unity.
//
// Ports:
//   clk_100      in   system clock
//   reset        in   asynchronous active-high reset
//   key_valid    in   one-cycle strobe qualifying key_code
//   key_code     in   4'hA delay step, 4'hB attenuation step, 4'hC bypass toggle
//   sample_tick  in   one-cycle strobe per codec sample
//   delay_sel    out  current delay tap index
//   atten_sel    out  current attenuation index
//   bypass       out  high passes the dry sample
//   gain         out  output gain, 255 = unity
//   delay_apply  out  one-cycle pulse with each delay_sel update (buffer flush)
//   busy         out  high while a delay change is in progress
module echo_ctrl_sequencer #(
  parameter int NUM_DELAYS = 8,
  parameter int NUM_ATTEN  = 4,
  parameter int RAMP_STEP  = 16,
  parameter int HOLD_TICKS = 64
) (
  input  logic                          clk_100,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  input  logic                          sample_tick,
  output logic [$clog2(NUM_DELAYS)-1:0] delay_sel,
  output logic [$clog2(NUM_ATTEN)-1:0]  atten_sel,
  output logic                          bypass,
  output logic [7:0]                    gain,
  output logic                          delay_apply,
  output logic                          busy
);

  localparam int DW = $clog2(NUM_DELAYS);
  localparam int AW = $clog2(NUM_ATTEN);
  localparam logic [DW-1:0] PEND_MAX = DW'(NUM_DELAYS - 1);
  localparam logic [DW:0]   DEL_MOD  = (DW + 1)'(NUM_DELAYS);
  localparam logic [AW-1:0] ATT_MAX  = AW'(NUM_ATTEN - 1);

  logic          key_delay;
  logic          key_atten;
  logic          key_bypass;
  logic          atten_req;
  logic          byp_req;
  logic [DW-1:0] pend;
  logic [DW-1:0] pend_inc;
  logic [DW:0]   delay_raw;
  logic [DW-1:0] delay_next;

  assign key_delay  = key_valid && (key_code == 4'hA);
  assign key_atten  = key_valid && (key_code == 4'hB);
  assign key_bypass = key_valid && (key_code == 4'hC);

  // Pending steps saturate: more than NUM_DELAYS-1 steps would alias.
  assign pend_inc = (pend == PEND_MAX) ? pend : pend + 1'b1;

  // Both operands are below NUM_DELAYS, so one conditional subtract wraps.
  assign delay_raw  = {1'b0, delay_sel} + {1'b0, pend};
  assign delay_next = (delay_raw >= DEL_MOD) ? DW'(delay_raw - DEL_MOD) : DW'(delay_raw);

  // Attenuation and bypass requests. The key assignment comes last so a key
  // coincident with a tick survives to the following tick.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      atten_sel <= '0;
      bypass    <= 1'b0;
      atten_req <= 1'b0;
      byp_req   <= 1'b0;
    end else begin
      if (sample_tick) begin
        if (atten_req) begin
          atten_sel <= (atten_sel == ATT_MAX) ? '0 : atten_sel + 1'b1;
          atten_req <= 1'b0;
        end
        if (byp_req) begin
          bypass  <= ~bypass;
          byp_req <= 1'b0;
        end
      end
      if (key_atten)  atten_req <= 1'b1;
      if (key_bypass) byp_req   <= 1'b1;
    end
  end

`ifdef ECHO_CTRL_RAMP_EN

  localparam logic [7:0] STEP      = 8'(RAMP_STEP);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  typedef enum logic [2:0] {IDLE, RAMP_DN, APPLY, HOLD, RAMP_UP} state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [7:0] gain_dn;
  logic [7:0] gain_up;

  assign gain_dn = (gain > STEP) ? gain - STEP : 8'd0;
  assign gain_up = ((8'd255 - gain) > STEP) ? gain + STEP : 8'd255;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      hold_cnt    <= '0;
      delay_sel   <= '0;
      gain        <= 8'd255;
      delay_apply <= 1'b0;
      busy        <= 1'b0;
    end else begin
      delay_apply <= 1'b0;
      if (key_delay) pend <= pend_inc;
      case (state)
        IDLE: begin
          if (pend != '0) begin
            state <= RAMP_DN;
            busy  <= 1'b1;
          end
        end
        RAMP_DN: begin
          // A re-trigger from RAMP_UP can arrive with gain already at 0.
          if (gain == 8'd0) begin
            state <= APPLY;
          end else if (sample_tick) begin
            gain <= gain_dn;
            if (gain_dn == 8'd0) state <= APPLY;
          end
        end
        APPLY: begin
          delay_sel   <= delay_next;
          delay_apply <= 1'b1;
          // A key in this cycle is the first step of the next change.
          pend        <= key_delay ? DW'(1) : '0;
          hold_cnt    <= HOLD_INIT;
          state       <= HOLD;
        end
        HOLD: begin
          if (sample_tick) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt <= 8'd1) state <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (pend != '0) begin
            state <= RAMP_DN;
          end else if (sample_tick) begin
            gain <= gain_up;
            if (gain_up == 8'd255) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  // Without the ramp the only states are IDLE and APPLY (waiting for a
  // tick); a nonzero pending count is exactly the APPLY state.
  logic          apply_now;
  logic [DW-1:0] pend_next;

  assign apply_now = sample_tick && (pend != '0);

  always_comb begin
    pend_next = pend;
    if (apply_now) pend_next = '0;
    if (key_delay) pend_next = apply_now ? DW'(1) : pend_inc;
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      pend        <= '0;
      delay_sel   <= '0;
      delay_apply <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pend        <= pend_next;
      delay_apply <= apply_now;
      busy        <= (pend_next != '0);
      if (apply_now) delay_sel <= delay_next;
    end
  end

  assign gain = 8'd255;

`endif

endmodule

// File: tb/tb_echo_ctrl_sequencer.sv
// Testbench for echo_ctrl_sequencer (NUM_DELAYS=8, NUM_ATTEN=4, RAMP_STEP=16,
// HOLD_TICKS=4). Delay-apply pulses are checked against a queue of expected
// tap indices pushed when the stimulus that causes them is driven.
module tb_echo_ctrl_sequencer;

  logic       clk_100 = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       sample_tick;
  logic [2:0] delay_sel;
  logic [1:0] atten_sel;
  logic       bypass;
  logic [7:0] gain;
  logic       delay_apply;
  logic       busy;

  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  logic [7:0] prev_gain = 8'd255;
  int   gain_delta;
  bit   seen_full;
  int   d0;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       tk;
    logic       app;
    int         dsel;
    int         att;
    int         byp;
    int         bsy;
  } vec_t;

  vec_t vecs[$];

  echo_ctrl_sequencer #(
    .NUM_DELAYS(8),
    .NUM_ATTEN (4),
    .RAMP_STEP (16),
    .HOLD_TICKS(4)
  ) dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .sample_tick(sample_tick),
    .delay_sel  (delay_sel),
    .atten_sel  (atten_sel),
    .bypass     (bypass),
    .gain       (gain),
    .delay_apply(delay_apply),
    .busy       (busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic kv, input logic [3:0] kc, input logic tk, input logic app,
                     input int dsel, input int att, input int byp, input int bsy);
    vecs.push_back('{kv, kc, tk, app, dsel, att, byp, bsy});
  endtask

  task automatic drive(input logic kv, input logic [3:0] kc, input logic tk);
    key_valid   = kv;
    key_code    = kc;
    sample_tick = tk;
    @(posedge clk_100);
    #1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic period();
    idle(9);
    drive(1'b0, 4'h0, 1'b1);
  endtask

  // Run at a 10-cycle tick cadence until mode 0: apply pulse, mode 1: busy low.
  task automatic run_until(input int mode, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      drive(1'b0, 4'h0, (i % 10) == 9);
      if (gain == 8'd255) seen_full = 1'b1;
      hit = (mode == 0) ? delay_apply : !busy;
    end
    chk(name, int'(hit), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dsel"},  int'(delay_sel),   0);
    chk({tag, "_att"},   int'(atten_sel),   0);
    chk({tag, "_byp"},   int'(bypass),      0);
    chk({tag, "_gain"},  int'(gain),        255);
    chk({tag, "_apply"}, int'(delay_apply), 0);
    chk({tag, "_busy"},  int'(busy),        0);
  endtask

  // Scoreboard side: every apply pulse must match the oldest expected tap.
  always @(negedge clk_100) begin
    if (delay_apply) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL apply_unexpected actual=pulse dsel=%0d required=no pulse", delay_sel);
      end else begin
        chk("apply_dsel", int'(delay_sel), exp_q.pop_front());
      end
    end
    if (!reset && gain != prev_gain) begin
      gain_delta = int'(gain) - int'(prev_gain);
      chk("gain_step_size", int'(gain_delta <= 16 && gain_delta >= -16), 1);
    end
    prev_gain = gain;
  end

  initial begin
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    sample_tick = 1'b0;

`ifdef ECHO_CTRL_RAMP_EN
    d0 = 0;
`else
    // kv kc tk | app dsel att byp busy
    add(1, 4'hA, 0, 0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 4'hA, 0, 0, 1, 0, 0, 1);
    add(0, 4'h0, 1, 1, 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'hA, 0, 0, 6, 0, 0, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0, 0);
    add(1, 4'hA, 1, 0, 1, 0, 0, 1);
    add(1, 4'hA, 1, 1, 2, 0, 0, 1);
    add(0, 4'h0, 1, 1, 3, 0, 0, 0);
    add(0, 4'h0, 0, 0, 3, 0, 0, 0);
    d0 = 3;
`endif
    add(1, 4'hB, 0, 0, d0, 0, 0, 0);
    add(0, 4'h0, 1, 0, d0, 1, 0, 0);
    add(1, 4'hB, 0, 0, d0, 1, 0, 0);
    add(0, 4'h0, 1, 0, d0, 2, 0, 0);
    add(1, 4'hB, 0, 0, d0, 2, 0, 0);
    add(0, 4'h0, 1, 0, d0, 3, 0, 0);
    add(1, 4'hB, 0, 0, d0, 3, 0, 0);
    add(1, 4'hB, 0, 0, d0, 3, 0, 0);
    add(0, 4'h0, 1, 0, d0, 0, 0, 0);
    add(0, 4'h0, 1, 0, d0, 0, 0, 0);
    add(1, 4'hC, 1, 0, d0, 0, 0, 0);
    add(0, 4'h0, 0, 0, d0, 0, 0, 0);
    add(0, 4'h0, 1, 0, d0, 0, 1, 0);
    add(1, 4'hC, 0, 0, d0, 0, 1, 0);
    add(1, 4'hC, 0, 0, d0, 0, 1, 0);
    add(0, 4'h0, 1, 0, d0, 0, 0, 0);
    add(1, 4'hB, 1, 0, d0, 0, 0, 0);
    add(0, 4'h0, 1, 0, d0, 1, 0, 0);

    #23 reset = 1'b0;
    @(posedge clk_100);
    #1;
    check_reset_vals("rst");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].app) exp_q.push_back(vecs[i].dsel);
      drive(vecs[i].kv, vecs[i].kc, vecs[i].tk);
      $display("vec %0d key=%0b/%h tick=%0b -> dsel=%0d att=%0d byp=%0b gain=%0d apply=%0b busy=%0b",
               i, vecs[i].kv, vecs[i].kc, vecs[i].tk, delay_sel, atten_sel, bypass, gain,
               delay_apply, busy);
      chk("vec_dsel",  int'(delay_sel),   vecs[i].dsel);
      chk("vec_att",   int'(atten_sel),   vecs[i].att);
      chk("vec_byp",   int'(bypass),      vecs[i].byp);
      chk("vec_busy",  int'(busy),        vecs[i].bsy);
      chk("vec_apply", int'(delay_apply), int'(vecs[i].app));
      chk("vec_gain",  int'(gain),        255);
    end

`ifdef ECHO_CTRL_RAMP_EN
    // Basic delay step: full ramp down, apply, hold, ramp up.
    exp_q.push_back(1);
    drive(1'b1, 4'hA, 1'b0);
    chk("t1_busy_at_key", int'(busy), 0);
    idle(1);
    chk("t1_busy_rise", int'(busy), 1);
    for (int i = 1; i <= 16; i++) begin
      period();
      chk("t1_gain_dn", int'(gain), (255 - 16 * i > 0) ? 255 - 16 * i : 0);
    end
    idle(1);
    $display("t1 apply: dsel=%0d apply=%0b", delay_sel, delay_apply);
    chk("t1_apply", int'(delay_apply), 1);
    chk("t1_dsel", int'(delay_sel), 1);
    idle(1);
    chk("t1_apply_one_cycle", int'(delay_apply), 0);
    for (int i = 1; i <= 4; i++) begin
      period();
      chk("t1_gain_hold", int'(gain), 0);
    end
    for (int i = 1; i <= 16; i++) begin
      period();
      chk("t1_gain_up", int'(gain), (16 * i < 255) ? 16 * i : 255);
      chk("t1_busy_up", int'(busy), (i < 16) ? 1 : 0);
    end

    // Coalescing and wrap: 1 -> 6, then 6 + 3 wraps to 1.
    exp_q.push_back(6);
    repeat (5) drive(1'b1, 4'hA, 1'b0);
    run_until(1, "t2a_done");
    chk("t2a_dsel", int'(delay_sel), 6);
    exp_q.push_back(1);
    repeat (3) drive(1'b1, 4'hA, 1'b0);
    run_until(1, "t2b_done");
    $display("t2 wrap: dsel=%0d", delay_sel);
    chk("t2b_dsel", int'(delay_sel), 1);

    // Re-trigger during ramp-up at gain 128.
    exp_q.push_back(2);
    drive(1'b1, 4'hA, 1'b0);
    idle(1);
    repeat (16) period();
    idle(1);
    repeat (4) period();
    repeat (8) period();
    chk("t4_gain_mid", int'(gain), 128);
    drive(1'b1, 4'hA, 1'b0);
    idle(1);
    chk("t4_busy", int'(busy), 1);
    period();
    chk("t4_gain_redn", int'(gain), 112);
    exp_q.push_back(3);
    seen_full = 1'b0;
    run_until(0, "t4_apply");
    chk("t4_no_unity", int'(seen_full), 0);
    run_until(1, "t4_done");
    $display("t4 retrigger: dsel=%0d", delay_sel);
    chk("t4_dsel", int'(delay_sel), 3);

    // Reset in HOLD with two steps pending.
    exp_q.push_back(4);
    drive(1'b1, 4'hA, 1'b0);
    run_until(0, "t5_apply");
    drive(1'b1, 4'hA, 1'b0);
    drive(1'b1, 4'hA, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("t5_async");
    @(negedge clk_100);
    #2 reset = 1'b0;
    repeat (30) period();
    $display("t5 after reset: dsel=%0d gain=%0d busy=%0b", delay_sel, gain, busy);
    chk("t5_dsel", int'(delay_sel), 0);
    chk("t5_gain", int'(gain), 255);
    chk("t5_busy", int'(busy), 0);
`else
    // Saturation: nine keys collapse to seven steps, (3 + 7) mod 8 = 2.
    repeat (9) drive(1'b1, 4'hA, 1'b0);
    exp_q.push_back(2);
    drive(1'b0, 4'h0, 1'b1);
    $display("sat: dsel=%0d apply=%0b", delay_sel, delay_apply);
    chk("sat_dsel", int'(delay_sel), 2);
    chk("sat_apply", int'(delay_apply), 1);

    // Reset with a step pending: everything clears, nothing is applied later.
    drive(1'b1, 4'hA, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk_100);
    #2 reset = 1'b0;
    repeat (3) period();
    $display("rst_mid after release: dsel=%0d busy=%0b", delay_sel, busy);
    chk("rst_mid_dsel_after", int'(delay_sel), 0);
    chk("rst_mid_busy_after", int'(busy), 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
